prbs_checker: RTL and testbench
===============================

Name: prbs_checker

Overview:
- Serial receive-side checker for the Fibonacci LFSR pattern generator, using the same shift-register and tap convention.
- Self-synchronises to an incoming PRBS bit stream, declares lock, then counts bit errors and flags loss of sync.
- Sits at the far end of a link or loopback path under test.

Parameters:
N, 3, LFSR length in bits; shift register indexed [1:N], [1] newest bit
TAP_MASK, 3'b110, feedback taps; bit k-1 set => sr[k] in XOR (default = sr[3]^sr[2], period 7)
LOCK_COUNT, 8, consecutive correct predictions required to declare lock
WINDOW, 16, valid-bit window length for loss-of-sync detection while locked
LOSS_THRESH, 4, errors within one window that declare loss of sync
ERR_W, 8, width of error counter

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
bit_in  input  1  received PRBS bit
bit_valid  input  1  bit_in is sampled only on edges where high
clr_cnt  input  1  clears err_count and sync_lost
locked  output  1  checker in LOCKED state
err_pulse  output  1  one-cycle pulse per errored bit while locked
err_count  output  ERR_W  saturating count of errored bits while locked
sync_lost  output  1  sticky loss-of-sync flag

Behaviour:
- One clock (clk); reset is synchronous and active-high (reset). Reset clears all outputs and state to 0; FSM -> HUNT.
- Reset mid-operation: same as power-up; partially filled sr and counters discarded.
- All outputs registered. bit_valid=0 cycle: no state change, err_pulse=0.
- pred = XOR of sr[k] over TAP_MASK taps.
- HUNT: each valid bit shifts in (sr <= {bit_in, sr[1:N-1]}); fill counter increments. After N bits -> VERIFY with match_cnt=0. If sr would be all-zero at that point, stay in HUNT, keep shifting (zero lock-up guard).
- VERIFY: each valid bit shifts bit_in into sr (self-sync). bit_in==pred: match_cnt++. Mismatch: match_cnt=0, stay VERIFY.
- On the edge accepting the LOCK_COUNT-th consecutive match: -> LOCKED, locked=1. Window counters start at 0.
- With defaults, continuous valid from reset gives locked=1 on the edge of the 11th valid bit.
- LOCKED: sr shifts in pred, not bit_in, so one line error costs exactly one error.
- LOCKED mismatch: err_pulse=1 for the following cycle; err_count++ (saturates at all-ones); win_err++.
- win_bits counts valid bits. On the WINDOW-th bit, win_bits and win_err reset to 0; an error on that bit is counted before the reset.
- When win_err (including the current bit) reaches LOSS_THRESH: sync_lost <= 1; behaviour then per the optional feature.
- clr_cnt and error on the same edge: clear first, then count => err_count=1, sync_lost reflects the current-cycle evaluation.
- err_pulse and err_count change only in LOCKED. locked stays 0 in HUNT and VERIFY.

Optional Feature:
- PRBS_AUTO_RESYNC_EN defined: on loss of sync the FSM -> HUNT, locked <= 0 on the same edge, fill and match counters cleared. err_count is retained and the checker relocks automatically.
- Undefined: the FSM stays LOCKED. Only sync_lost is set; error counting continues.

Test Plan:
- Defaults, reset, then stream 1,0,1,1,1,0,0 repeated with valid every cycle -> locked=1 at edge of 11th bit; err_count=0 after 100 bits.
- After lock, invert one bit -> err_pulse high exactly 1 cycle, err_count=1, locked stays 1, no further errors.
- All-zero stream, 50 valid bits -> FSM never leaves HUNT, locked=0.
- 4 inverted bits within one 16-bit window -> sync_lost=1. Macro on: locked drops that edge, relocks 11 good bits later. Macro off: locked stays 1, err_count=4.
- Macro off, inverted stream after lock -> err_count saturates at 255. clr_cnt pulsed concurrently with an error -> err_count=1.
- bit_valid toggled 1/0 during lock sequence -> lock after 11 valid bits. Reset asserted mid-VERIFY -> all outputs 0 next cycle; relock needs 11 fresh bits.

Source files
------------

// File: rtl/prbs_checker.sv
// prbs_checker: self-synchronising receive checker for a Fibonacci LFSR PRBS stream (sr[1] newest).
// Optional PRBS_AUTO_RESYNC_EN: on loss of sync, drop lock and hunt again automatically.
module prbs_checker #(
    parameter int           N           = 3,
    parameter logic [N-1:0] TAP_MASK    = 3'b110,
    parameter int           LOCK_COUNT  = 8,
    parameter int           WINDOW      = 16,
    parameter int           LOSS_THRESH = 4,
    parameter int           ERR_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic             sync_lost
);

    typedef enum logic [1:0] {HUNT = 2'd0, VERIFY = 2'd1, LOCKED = 2'd2} state_t;

    localparam int FILL_W  = $clog2(N + 1);
    localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam int WIN_W   = $clog2(WINDOW + 1);

    localparam logic [FILL_W-1:0]  FILL_LAST  = FILL_W'(N - 1);
    localparam logic [FILL_W-1:0]  FILL_ONE   = FILL_W'(1);
    localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_COUNT - 1);
    localparam logic [MATCH_W-1:0] MATCH_ONE  = MATCH_W'(1);
    localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(WINDOW - 1);
    localparam logic [WIN_W-1:0]   WIN_ONE    = WIN_W'(1);
    localparam logic [WIN_W-1:0]   LOSS_LIM   = WIN_W'(LOSS_THRESH);
    localparam logic [ERR_W-1:0]   ERR_MAX    = '1;
    localparam logic [ERR_W-1:0]   ERR_ONE    = ERR_W'(1);

    state_t             state_q, state_d;
    logic [1:N]         sr_q, sr_d;
    logic [1:N]         shifted;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic [WIN_W-1:0]   win_bits_q, win_bits_d;
    logic [WIN_W-1:0]   win_err_q, win_err_d;
    logic [WIN_W-1:0]   win_err_sum;
    logic [ERR_W-1:0]   err_count_q, err_count_d;
    logic               locked_q, locked_d;
    logic               err_pulse_q, err_pulse_d;
    logic               sync_lost_q, sync_lost_d;
    logic               pred;
    logic               mismatch;
    logic               loss;

    always_comb begin
        pred = 1'b0;
        for (int k = 1; k <= N; k++) begin
            if (TAP_MASK[k-1]) pred = pred ^ sr_q[k];
        end
    end

    assign shifted     = {bit_in, sr_q[1:N-1]};
    assign mismatch    = bit_in ^ pred;
    assign win_err_sum = win_err_q + {{(WIN_W-1){1'b0}}, mismatch};
    assign loss        = (win_err_sum >= LOSS_LIM);

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        fill_d      = fill_q;
        match_d     = match_q;
        win_bits_d  = win_bits_q;
        win_err_d   = win_err_q;
        err_pulse_d = 1'b0;
        // A clear lands before any error counted on the same edge.
        err_count_d = clr_cnt ? '0 : err_count_q;
        sync_lost_d = clr_cnt ? 1'b0 : sync_lost_q;

        if (bit_valid) begin
            case (state_q)
                HUNT: begin
                    sr_d = shifted;
                    if (fill_q != FILL_LAST) begin
                        fill_d = fill_q + FILL_ONE;
                    end else if (shifted != '0) begin
                        state_d = VERIFY;
                        match_d = '0;
                    end
                end
                VERIFY: begin
                    sr_d = shifted;
                    if (mismatch) begin
                        match_d = '0;
                    end else if (match_q == MATCH_LAST) begin
                        state_d    = LOCKED;
                        win_bits_d = '0;
                        win_err_d  = '0;
                    end else begin
                        match_d = match_q + MATCH_ONE;
                    end
                end
                LOCKED: begin
                    // Flywheel on the prediction so a line error is counted once only.
                    sr_d = {pred, sr_q[1:N-1]};
                    if (mismatch) begin
                        err_pulse_d = 1'b1;
                        if (err_count_d != ERR_MAX) err_count_d = err_count_d + ERR_ONE;
                    end
                    if (win_bits_q == WIN_LAST) begin
                        win_bits_d = '0;
                        win_err_d  = '0;
                    end else begin
                        win_bits_d = win_bits_q + WIN_ONE;
                        win_err_d  = win_err_sum;
                    end
                    if (loss) begin
                        sync_lost_d = 1'b1;
`ifdef PRBS_AUTO_RESYNC_EN
                        state_d    = HUNT;
                        fill_d     = '0;
                        match_d    = '0;
                        win_bits_d = '0;
                        win_err_d  = '0;
`endif
                    end
                end
                default: state_d = HUNT;
            endcase
        end

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= HUNT;
            sr_q        <= '0;
            fill_q      <= '0;
            match_q     <= '0;
            win_bits_q  <= '0;
            win_err_q   <= '0;
            err_count_q <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            sync_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            fill_q      <= fill_d;
            match_q     <= match_d;
            win_bits_q  <= win_bits_d;
            win_err_q   <= win_err_d;
            err_count_q <= err_count_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            sync_lost_q <= sync_lost_d;
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;
    assign sync_lost = sync_lost_q;

endmodule

// File: tb/tb_prbs_checker.sv
// tb_prbs_checker: directed and randomized stimulus for prbs_checker against a bit-history model.
// Honours PRBS_AUTO_RESYNC_EN the same way the design does.
module tb_prbs_checker;

    localparam int           N           = 3;
    localparam logic [N-1:0] TAP_MASK    = 3'b110;
    localparam int           LOCK_COUNT  = 8;
    localparam int           WINDOW      = 16;
    localparam int           LOSS_THRESH = 4;
    localparam int           ERR_W       = 8;
    localparam int           ERR_MAX     = (1 << ERR_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             bit_in = 1'b0;
    logic             bit_valid = 1'b0;
    logic             clr_cnt = 1'b0;
    logic             locked;
    logic             err_pulse;
    logic [ERR_W-1:0] err_count;
    logic             sync_lost;

    prbs_checker #(
        .N(N), .TAP_MASK(TAP_MASK), .LOCK_COUNT(LOCK_COUNT),
        .WINDOW(WINDOW), .LOSS_THRESH(LOSS_THRESH), .ERR_W(ERR_W)
    ) dut (
        .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
        .clr_cnt(clr_cnt), .locked(locked), .err_pulse(err_pulse),
        .err_count(err_count), .sync_lost(sync_lost)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit check_en = 1'b0;

    // Model: mode 0 hunting, 1 verifying, 2 locked; history holds the last N bits, newest first.
    int m_mode;
    int m_hist[$];
    int m_fill, m_run, m_wpos, m_werr;
    int exp_locked, exp_pulse, exp_count, exp_lost;

    int pattern[7] = '{1, 0, 1, 1, 1, 0, 0};
    int pidx = 0;

    function automatic logic nextBit();
        logic b;
        b = pattern[pidx][0];
        pidx = (pidx + 1) % 7;
        return b;
    endfunction

    function automatic int predict();
        int p = 0;
        for (int k = 0; k < N; k++) if (TAP_MASK[k]) p = p ^ m_hist[k];
        return p;
    endfunction

    function automatic bit histNonZero();
        int s = 0;
        foreach (m_hist[i]) s += m_hist[i];
        return s != 0;
    endfunction

    task automatic pushBit(input int v);
        m_hist.push_front(v);
        if (m_hist.size() > N) void'(m_hist.pop_back());
    endtask

    task automatic modelReset();
        m_mode = 0; m_hist.delete(); m_fill = 0; m_run = 0; m_wpos = 0; m_werr = 0;
        exp_locked = 0; exp_pulse = 0; exp_count = 0; exp_lost = 0;
    endtask

    task automatic modelStep(input logic v, input logic b, input logic c);
        int p;
        bit lost_now;
        exp_pulse = 0;
        if (c) begin
            exp_count = 0;
            exp_lost = 0;
        end
        if (v) begin
            case (m_mode)
                0: begin
                    pushBit(int'(b));
                    m_fill++;
                    if (m_fill >= N && histNonZero()) begin
                        m_mode = 1;
                        m_run = 0;
                    end
                end
                1: begin
                    p = predict();
                    pushBit(int'(b));
                    if (int'(b) == p) begin
                        m_run++;
                        if (m_run == LOCK_COUNT) begin
                            m_mode = 2; m_wpos = 0; m_werr = 0;
                        end
                    end else begin
                        m_run = 0;
                    end
                end
                default: begin
                    p = predict();
                    pushBit(p);
                    if (int'(b) != p) begin
                        exp_pulse = 1;
                        if (exp_count < ERR_MAX) exp_count++;
                        m_werr++;
                    end
                    m_wpos++;
                    lost_now = (m_werr >= LOSS_THRESH);
                    if (lost_now) exp_lost = 1;
                    if (m_wpos == WINDOW) begin
                        m_wpos = 0;
                        m_werr = 0;
                    end
`ifdef PRBS_AUTO_RESYNC_EN
                    if (lost_now) begin
                        m_mode = 0; m_hist.delete(); m_fill = 0; m_run = 0;
                    end
`endif
                end
            endcase
        end
        exp_locked = (m_mode == 2) ? 1 : 0;
    endtask

    task automatic compareVal(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d t=%0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkOutput();
        compareVal("locked", int'(locked), exp_locked);
        compareVal("err_pulse", int'(err_pulse), exp_pulse);
        compareVal("err_count", int'(err_count), exp_count);
        compareVal("sync_lost", int'(sync_lost), exp_lost);
    endtask

    always @(negedge clk) begin
        if (check_en) checkOutput();
    end

    task automatic applyStimulus(input logic v, input logic b, input logic c);
        bit_valid = v;
        bit_in    = b;
        clr_cnt   = c;
        @(posedge clk);
        modelStep(v, b, c);
        @(negedge clk);
    endtask

    task automatic applyReset();
        reset     = 1'b1;
        bit_valid = 1'b1;
        bit_in    = 1'($urandom_range(0, 1));
        clr_cnt   = 1'b0;
        @(posedge clk);
        modelReset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic feedGood(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, nextBit(), 1'b0);
    endtask

    task automatic feedBad(input int n, input logic c);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, ~nextBit(), c);
    endtask

    initial begin
        logic rv, rb, rc;
        int r;

        @(negedge clk);
        applyReset();
        check_en = 1'b1;
        applyReset();
        compareVal("reset_locked", int'(locked), 0);
        compareVal("reset_err_count", int'(err_count), 0);
        compareVal("reset_sync_lost", int'(sync_lost), 0);
        compareVal("reset_err_pulse", int'(err_pulse), 0);

        $display("[TB] lock on clean stream");
        pidx = 0;
        feedGood(10);
        compareVal("locked_after_10", int'(locked), 0);
        feedGood(1);
        compareVal("locked_at_11", int'(locked), 1);
        compareVal("model_locked_at_11", exp_locked, 1);
        feedGood(89);
        compareVal("err_count_after_100", int'(err_count), 0);

        $display("[TB] single inverted bit");
        feedBad(1, 1'b0);
        compareVal("single_err_pulse", int'(err_pulse), 1);
        feedGood(1);
        compareVal("single_err_pulse_width", int'(err_pulse), 0);
        compareVal("single_err_count", int'(err_count), 1);
        compareVal("model_single_err_count", exp_count, 1);
        compareVal("single_err_locked", int'(locked), 1);
        feedGood(30);
        compareVal("single_err_no_more", int'(err_count), 1);

        $display("[TB] loss of sync");
        applyReset();
        pidx = 0;
        feedGood(13);
        feedBad(4, 1'b0);
        compareVal("loss_sync_lost", int'(sync_lost), 1);
        compareVal("loss_err_count", int'(err_count), 4);
`ifdef PRBS_AUTO_RESYNC_EN
        compareVal("loss_locked_drop", int'(locked), 0);
        feedGood(10);
        compareVal("relock_after_10", int'(locked), 0);
        feedGood(1);
        compareVal("relock_at_11", int'(locked), 1);
        compareVal("relock_err_count_kept", int'(err_count), 4);
`else
        compareVal("loss_locked_kept", int'(locked), 1);
        feedBad(300, 1'b0);
        compareVal("err_count_saturated", int'(err_count), 255);
        compareVal("model_err_count_saturated", exp_count, 255);
        feedBad(1, 1'b1);
        compareVal("clr_with_err_after_sat", int'(err_count), 1);
`endif

        $display("[TB] clear concurrent with error");
        applyReset();
        pidx = 0;
        feedGood(14);
        feedBad(1, 1'b1);
        compareVal("clr_with_err_count", int'(err_count), 1);
        compareVal("clr_with_err_pulse", int'(err_pulse), 1);
        compareVal("clr_with_err_sync_lost", int'(sync_lost), 0);

        $display("[TB] all-zero stream");
        applyReset();
        for (int i = 0; i < 50; i++) applyStimulus(1'b1, 1'b0, 1'b0);
        compareVal("zero_stream_locked", int'(locked), 0);
        compareVal("model_zero_stream_locked", exp_locked, 0);

        $display("[TB] gapped valid");
        applyReset();
        pidx = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, nextBit(), 1'b0);
            applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'b0);
        end
        compareVal("gapped_locked_after_10", int'(locked), 0);
        feedGood(1);
        compareVal("gapped_locked_at_11", int'(locked), 1);

        $display("[TB] reset mid-verify");
        applyReset();
        pidx = 0;
        feedGood(6);
        applyReset();
        compareVal("midreset_locked", int'(locked), 0);
        compareVal("midreset_err_count", int'(err_count), 0);
        compareVal("midreset_sync_lost", int'(sync_lost), 0);
        feedGood(10);
        compareVal("midreset_locked_after_10", int'(locked), 0);
        feedGood(1);
        compareVal("midreset_locked_at_11", int'(locked), 1);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 2500; i++) begin
            r = $urandom_range(0, 999);
            if (r < 2) begin
                applyReset();
            end else begin
                rv = ($urandom_range(0, 3) != 0);
                rc = ($urandom_range(0, 99) == 0);
                if (i >= 1200 && i < 1320) begin
                    rb = 1'($urandom_range(0, 1));
                end else if (rv) begin
                    rb = nextBit();
                    if ($urandom_range(0, 29) == 0) rb = ~rb;
                end else begin
                    rb = 1'($urandom_range(0, 1));
                end
                applyStimulus(rv, rb, rc);
            end
        end

        bit_valid = 1'b0;
        clr_cnt   = 1'b0;
        @(posedge clk);
        modelStep(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #2;
        check_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
